// File: rtl/conv_column_feeder_if.sv
// Column-feeder bus: kernel/width/start control, row-memory read port and the
// column push interface towards the 3x3 convolutor.
interface conv_column_feeder_if #(
  parameter int BIT_LEN  = 8,
  parameter int ADDR_LEN = 11
);
  logic                   i_start;
  logic [ADDR_LEN-1:0]    i_width;
  logic [9*BIT_LEN-1:0]   i_kernel;
  logic                   i_stall;
  logic [ADDR_LEN-1:0]    o_addr;
  logic [BIT_LEN-1:0]     i_mem0;
  logic [BIT_LEN-1:0]     i_mem1;
  logic [BIT_LEN-1:0]     i_mem2;
  logic [BIT_LEN-1:0]     o_dato0;
  logic [BIT_LEN-1:0]     o_dato1;
  logic [BIT_LEN-1:0]     o_dato2;
  logic                   o_selK_I;
  logic                   o_valid;
  logic                   o_res_valid;
  logic                   o_busy;
  logic                   o_done;
  logic                   o_err;

  // master is the feeder itself; slave is the surrounding control/memory side
  modport master (
    input  i_start, i_width, i_kernel, i_stall, i_mem0, i_mem1, i_mem2,
    output o_addr, o_dato0, o_dato1, o_dato2, o_selK_I, o_valid,
           o_res_valid, o_busy, o_done, o_err
  );

  modport slave (
    output i_start, i_width, i_kernel, i_stall, i_mem0, i_mem1, i_mem2,
    input  o_addr, o_dato0, o_dato1, o_dato2, o_selK_I, o_valid,
           o_res_valid, o_busy, o_done, o_err
  );
endinterface

// File: rtl/conv_column_feeder.sv
// Feeds kernel columns then image columns (plus one flush column) into the 3x3 convolutor.
// Define CONV_FEEDER_ZERO_PAD_EN for "same"-size output (zero column before and after the row).
module conv_column_feeder #(
  parameter int BIT_LEN  = 8,
  parameter int ADDR_LEN = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  conv_column_feeder_if.master  bus
);

  localparam int PW = ADDR_LEN + 1;
  localparam logic [ADDR_LEN-1:0] ADDR_ONE = ADDR_LEN'(1);

`ifdef CONV_FEEDER_ZERO_PAD_EN
  localparam int MIN_WIDTH = 1;
`else
  localparam int MIN_WIDTH = 3;
`endif

  typedef enum logic [2:0] {
    IDLE, KLOAD, PAD_PRE, STREAM, PAD_POST, FLUSH, DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             kcol_q, kcol_d;
  logic [ADDR_LEN-1:0]    addr_q, addr_d;
  logic [ADDR_LEN-1:0]    width_q, width_d;
  logic [PW-1:0]          push_q, push_d;
  logic [9*BIT_LEN-1:0]   kernel_q, kernel_d;
  logic                   res_q, res_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic feeding;
  logic imagePush;
  logic lastCol;
  logic widthTooSmall;

  assign feeding = (state_q == KLOAD) || (state_q == PAD_PRE) || (state_q == STREAM) ||
                   (state_q == PAD_POST) || (state_q == FLUSH);
  assign imagePush = feeding && (state_q != KLOAD) && !bus.i_stall;
  assign lastCol = (addr_q == width_q - ADDR_ONE);
  assign widthTooSmall = ({1'b0, bus.i_width} < PW'(MIN_WIDTH));

  // addr_q tracks the pending image column; o_addr shows the next one so the
  // synchronous row memories deliver the pending column's data in step with it
  always_comb begin
    state_d  = state_q;
    kcol_d   = kcol_q;
    addr_d   = addr_q;
    width_d  = width_q;
    push_d   = push_q;
    kernel_d = kernel_q;
    res_d    = (feeding && bus.i_stall) ? res_q : 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          if (widthTooSmall) begin
            err_d = 1'b1;
          end else begin
            width_d  = bus.i_width;
            kernel_d = bus.i_kernel;
            kcol_d   = 2'd0;
            addr_d   = '0;
            push_d   = '0;
            state_d  = KLOAD;
          end
        end
      end
      KLOAD: begin
        if (!bus.i_stall) begin
          kcol_d = kcol_q + 2'd1;
          if (kcol_q == 2'd2) begin
            kcol_d = 2'd0;
`ifdef CONV_FEEDER_ZERO_PAD_EN
            state_d = PAD_PRE;
`else
            state_d = STREAM;
`endif
          end
        end
      end
      PAD_PRE: begin
        if (!bus.i_stall) state_d = STREAM;
      end
      STREAM: begin
        if (!bus.i_stall) begin
          if (lastCol) begin
`ifdef CONV_FEEDER_ZERO_PAD_EN
            state_d = PAD_POST;
`else
            state_d = FLUSH;
`endif
          end else begin
            addr_d = addr_q + ADDR_ONE;
          end
        end
      end
      PAD_POST: begin
        if (!bus.i_stall) state_d = FLUSH;
      end
      FLUSH: begin
        if (!bus.i_stall) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        addr_d  = '0;
      end
      default: state_d = IDLE;
    endcase

    // The convolutor output holds a full 3x3 window once three image columns precede the push
    if (imagePush) begin
      push_d = push_q + PW'(1);
      res_d  = (push_q >= PW'(3));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      kcol_q   <= '0;
      addr_q   <= '0;
      width_q  <= '0;
      push_q   <= '0;
      kernel_q <= '0;
      res_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      kcol_q   <= kcol_d;
      addr_q   <= addr_d;
      width_q  <= width_d;
      push_q   <= push_d;
      kernel_q <= kernel_d;
      res_q    <= res_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    bus.o_dato0 = '0;
    bus.o_dato1 = '0;
    bus.o_dato2 = '0;
    case (state_q)
      KLOAD: begin
        bus.o_dato0 = kernel_q[int'(kcol_q)*BIT_LEN +: BIT_LEN];
        bus.o_dato1 = kernel_q[(3 + int'(kcol_q))*BIT_LEN +: BIT_LEN];
        bus.o_dato2 = kernel_q[(6 + int'(kcol_q))*BIT_LEN +: BIT_LEN];
      end
      STREAM: begin
        bus.o_dato0 = bus.i_mem0;
        bus.o_dato1 = bus.i_mem1;
        bus.o_dato2 = bus.i_mem2;
      end
      default: ;
    endcase
  end

  assign bus.o_addr      = addr_d;
  assign bus.o_valid     = feeding && !bus.i_stall;
  assign bus.o_selK_I    = feeding && (state_q != KLOAD);
  assign bus.o_res_valid = res_q && !bus.i_stall;
  assign bus.o_busy      = (state_q != IDLE);
  assign bus.o_done      = done_q;
  assign bus.o_err       = err_q;

endmodule

// File: tb/tb_conv_column_feeder.sv
// Directed bench for conv_column_feeder: kernel k[r][c]=3r+c+1, W=5, memories return addr+{0,10,20}.
// Honours CONV_FEEDER_ZERO_PAD_EN for the padded column sequence.
module tb_conv_column_feeder;

  localparam int BIT_LEN  = 8;
  localparam int ADDR_LEN = 11;

`ifdef CONV_FEEDER_ZERO_PAD_EN
  localparam int N_PUSH     = 11;
  localparam int N_RES      = 5;
  localparam int BUSY_CYC   = 12;
  localparam int ERR_W      = 0;
  localparam int STALL_ADDR = 1;
  localparam logic [24:0] EXP_PUSH [N_PUSH] = '{
    {1'b0, 8'd1, 8'd4, 8'd7}, {1'b0, 8'd2, 8'd5, 8'd8}, {1'b0, 8'd3, 8'd6, 8'd9},
    {1'b1, 8'd0, 8'd0, 8'd0},
    {1'b1, 8'd0, 8'd10, 8'd20}, {1'b1, 8'd1, 8'd11, 8'd21}, {1'b1, 8'd2, 8'd12, 8'd22},
    {1'b1, 8'd3, 8'd13, 8'd23}, {1'b1, 8'd4, 8'd14, 8'd24},
    {1'b1, 8'd0, 8'd0, 8'd0}, {1'b1, 8'd0, 8'd0, 8'd0}
  };
`else
  localparam int N_PUSH     = 9;
  localparam int N_RES      = 3;
  localparam int BUSY_CYC   = 10;
  localparam int ERR_W      = 2;
  localparam int STALL_ADDR = 2;
  localparam logic [24:0] EXP_PUSH [N_PUSH] = '{
    {1'b0, 8'd1, 8'd4, 8'd7}, {1'b0, 8'd2, 8'd5, 8'd8}, {1'b0, 8'd3, 8'd6, 8'd9},
    {1'b1, 8'd0, 8'd10, 8'd20}, {1'b1, 8'd1, 8'd11, 8'd21}, {1'b1, 8'd2, 8'd12, 8'd22},
    {1'b1, 8'd3, 8'd13, 8'd23}, {1'b1, 8'd4, 8'd14, 8'd24},
    {1'b1, 8'd0, 8'd0, 8'd0}
  };
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_column_feeder_if #(.BIT_LEN(BIT_LEN), .ADDR_LEN(ADDR_LEN)) bus ();

  conv_column_feeder #(.BIT_LEN(BIT_LEN), .ADDR_LEN(ADDR_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Row memories with one cycle of read latency
  always @(posedge clk) begin
    bus.i_mem0 <= 8'(bus.o_addr);
    bus.i_mem1 <= 8'(bus.o_addr + 11'd10);
    bus.i_mem2 <= 8'(bus.o_addr + 11'd20);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observers sample mid-cycle and keep running totals across the whole run
  logic [24:0] pushLog [$];
  int resTotal = 0;
  int doneTotal = 0;
  int errTotal = 0;
  int busyTotal = 0;
  int lastPushCyc = 0;
  int doneCyc = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_valid) begin
        pushLog.push_back({bus.o_selK_I, bus.o_dato0, bus.o_dato1, bus.o_dato2});
        lastPushCyc = cyc;
      end
      if (bus.o_res_valid) resTotal++;
      if (bus.o_done) begin
        doneTotal++;
        doneCyc = cyc;
      end
      if (bus.o_err) errTotal++;
      if (bus.o_busy) busyTotal++;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic start, input int width, input logic stall);
    bus.i_start = start;
    bus.i_width = ADDR_LEN'(width);
    bus.i_stall = stall;
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkPass(input string tag, input int logStart, input int resStart,
                           input int doneStart, input int busyStart, input int extraBusy);
    logic [24:0] obs;
    checkOutput({tag, "_pushes"}, 32'(pushLog.size() - logStart), 32'(N_PUSH));
    for (int i = 0; i < N_PUSH; i++) begin
      obs = (logStart + i < pushLog.size()) ? pushLog[logStart + i] : 25'h1FFFFFF;
      checkOutput($sformatf("%s_col%0d", tag, i), 32'(obs), 32'(EXP_PUSH[i]));
    end
    checkOutput({tag, "_results"}, 32'(resTotal - resStart), 32'(N_RES));
    checkOutput({tag, "_done"}, 32'(doneTotal - doneStart), 32'd1);
    checkOutput({tag, "_busy"}, 32'(busyTotal - busyStart), 32'(BUSY_CYC + extraBusy));
    checkOutput({tag, "_doneLag"}, 32'(doneCyc - lastPushCyc), 32'd1);
  endtask

  int logStart, resStart, doneStart, busyStart, errStart;

  task automatic snapshot();
    logStart  = pushLog.size();
    resStart  = resTotal;
    doneStart = doneTotal;
    busyStart = busyTotal;
    errStart  = errTotal;
  endtask

  initial begin
    rst = 1'b1;
    bus.i_kernel = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    applyStimulus(1'b0, 0, 1'b0);
    tick(3);
    rst = 1'b0;
    #1;
    checkOutput("rst_valid", 32'(bus.o_valid), 32'd0);
    checkOutput("rst_busy", 32'(bus.o_busy), 32'd0);
    checkOutput("rst_addr", 32'(bus.o_addr), 32'd0);
    checkOutput("rst_dato0", 32'(bus.o_dato0), 32'd0);
    checkOutput("rst_selK", 32'(bus.o_selK_I), 32'd0);
    checkOutput("rst_res", 32'(bus.o_res_valid), 32'd0);
    checkOutput("rst_done", 32'(bus.o_done), 32'd0);
    checkOutput("rst_err", 32'(bus.o_err), 32'd0);

    // Plain pass, first kernel column one cycle after start
    tick(1);
    snapshot();
    applyStimulus(1'b1, 5, 1'b0);
    tick(1);
    applyStimulus(1'b0, 5, 1'b0);
    checkOutput("p1_firstValid", 32'(bus.o_valid), 32'd1);
    checkOutput("p1_firstSel", 32'(bus.o_selK_I), 32'd0);
    checkOutput("p1_firstDato2", 32'(bus.o_dato2), 32'd7);
    tick(14);
    checkPass("p1", logStart, resStart, doneStart, busyStart, 0);

    // Width below the minimum is rejected
    snapshot();
    applyStimulus(1'b1, ERR_W, 1'b0);
    tick(1);
    applyStimulus(1'b0, 5, 1'b0);
    checkOutput("err_pulse", 32'(bus.o_err), 32'd1);
    checkOutput("err_busy", 32'(bus.o_busy), 32'd0);
    checkOutput("err_valid", 32'(bus.o_valid), 32'd0);
    tick(1);
    checkOutput("err_clear", 32'(bus.o_err), 32'd0);
    tick(5);
    checkOutput("err_noPush", 32'(pushLog.size() - logStart), 32'd0);
    checkOutput("err_noBusy", 32'(busyTotal - busyStart), 32'd0);
    checkOutput("err_count", 32'(errTotal - errStart), 32'd1);

    // Four-cycle stall on the third image push
    snapshot();
    applyStimulus(1'b1, 5, 1'b0);
    tick(1);
    applyStimulus(1'b0, 5, 1'b0);
    tick(5);
    for (int s = 0; s < 4; s++) begin
      if (s != 0) tick(1);
      applyStimulus(1'b0, 5, 1'b1);
      checkOutput($sformatf("stall_valid%0d", s), 32'(bus.o_valid), 32'd0);
      checkOutput($sformatf("stall_addr%0d", s), 32'(bus.o_addr), 32'(STALL_ADDR));
    end
    tick(1);
    applyStimulus(1'b0, 5, 1'b0);
    checkOutput("stall_release", 32'(bus.o_valid), 32'd1);
    checkOutput("stall_relDato0", 32'(bus.o_dato0), 32'(STALL_ADDR));
    checkOutput("stall_relAddr", 32'(bus.o_addr), 32'(STALL_ADDR + 1));
    tick(12);
    checkPass("stall", logStart, resStart, doneStart, busyStart, 4);

    // Reset in the middle of streaming aborts without o_done
    snapshot();
    applyStimulus(1'b1, 5, 1'b0);
    tick(1);
    applyStimulus(1'b0, 5, 1'b0);
    tick(5);
    rst = 1'b1;
    #1;
    tick(1);
    rst = 1'b0;
    #1;
    checkOutput("abort_valid", 32'(bus.o_valid), 32'd0);
    checkOutput("abort_busy", 32'(bus.o_busy), 32'd0);
    checkOutput("abort_addr", 32'(bus.o_addr), 32'd0);
    checkOutput("abort_dato1", 32'(bus.o_dato1), 32'd0);
    checkOutput("abort_selK", 32'(bus.o_selK_I), 32'd0);
    checkOutput("abort_res", 32'(bus.o_res_valid), 32'd0);
    checkOutput("abort_done", 32'(bus.o_done), 32'd0);
    tick(12);
    checkOutput("abort_noDone", 32'(doneTotal - doneStart), 32'd0);

    snapshot();
    applyStimulus(1'b1, 5, 1'b0);
    tick(1);
    applyStimulus(1'b0, 5, 1'b0);
    tick(14);
    checkPass("clean", logStart, resStart, doneStart, busyStart, 0);

    // Second start while busy must be ignored
    snapshot();
    applyStimulus(1'b1, 5, 1'b0);
    tick(1);
    applyStimulus(1'b0, 5, 1'b0);
    tick(3);
    applyStimulus(1'b1, 3, 1'b0);
    tick(1);
    applyStimulus(1'b0, 5, 1'b0);
    tick(14);
    checkPass("busyStart", logStart, resStart, doneStart, busyStart, 0);
    checkOutput("busyStart_noErr", 32'(errTotal - errStart), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_column_feeder.md
Name: conv_column_feeder

Overview:
- Initiator side of the 3x3 convolutor column interface: drives kernel columns, then image columns, into the convolutor's dato0/1/2, selecK_I and valid inputs.
- Reads three image row memories (1-cycle read latency) over a shared address and loads the 9-tap kernel.
- Appends one flush column and flags which convolutor output cycles hold a complete 3x3 result.
- Sits between the row-buffer memories and the convolutor in the conv + control + FSM datapath.

Parameters:
- BIT_LEN, 8, pixel/tap width.
- ADDR_LEN, 11, row memory address width (max row width 2^ADDR_LEN-1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_start  in  1  1-cycle pulse; starts a row pass when idle
- i_width  in  ADDR_LEN  columns per row W, sampled on i_start
- i_kernel  in  9*BIT_LEN  tap k[r][c] at bits [(3r+c+1)*BIT_LEN-1 -: BIT_LEN], sampled on i_start
- i_stall  in  1  downstream hold; freezes the feeder
- o_addr  out  ADDR_LEN  row memory read address
- i_mem0 / i_mem1 / i_mem2  in  BIT_LEN each  row 0/1/2 read data, valid 1 cycle after o_addr
- o_dato0 / o_dato1 / o_dato2  out  BIT_LEN each  column to convolutor
- o_selK_I  out  1  0 = kernel column, 1 = image column
- o_valid  out  1  column push strobe
- o_res_valid  out  1  convolutor output register holds a complete result this cycle
- o_busy  out  1  pass in progress
- o_done  out  1  1-cycle pulse at end of pass
- o_err  out  1  1-cycle pulse: start rejected

Behaviour:
- Reset: all outputs 0, FSM IDLE, counters 0. rst mid-pass aborts immediately, with no o_done.
- States and transitions:
  - IDLE: on i_start, if W<3 pulse o_err next cycle and stay IDLE; otherwise latch W and kernel and go to KLOAD.
  - KLOAD: 3 cycles, c=0..2. Each cycle o_valid=1, o_selK_I=0, dato0/1/2 = k[0][c]/k[1][c]/k[2][c]. o_addr=0 is driven during the last KLOAD cycle (prefetch).
  - STREAM: pushes image columns 0..W-1; dato_n = registered i_mem_n, o_selK_I=1, o_addr increments by 1 per accepted column.
  - FLUSH: 1 push of an all-zero column with o_selK_I=1, so the last result is latched.
  - DONE: 1 cycle, o_done=1, then IDLE.
- Totals: 3 kernel pushes + W+1 image pushes.
- Latency: first kernel push is 1 cycle after i_start; first image push immediately follows the last kernel push (no bubble without stall).
- o_busy = 1 in KLOAD/STREAM/FLUSH/DONE.
- Result flag: image push index p (0-based) latches the convolution of columns p-3..p-1. o_res_valid=1 in the cycle after pushes p=3..W, giving exactly W-2 results per pass.
- Stall: while i_stall=1, o_valid=0, o_res_valid=0, and FSM, counters, o_addr and the data register are frozen. o_addr is held, so memory data stays consistent. The column pending when stall rose is pushed in the first cycle after i_stall falls. A stall during KLOAD behaves the same way.
- i_start while busy: ignored.
- i_start coinciding with rst: rst wins.
- Address never exceeds W-1; no wrap.

Optional Feature:
- CONV_FEEDER_ZERO_PAD_EN.
- Defined: one zero column is pushed before image column 0 and one after column W-1, in addition to the flush column. W+3 image pushes, W results ("same"-size output). W>=1 is accepted; o_err only for W=0.
- Undefined: behaviour exactly as above ("valid"-size, W-2 results).

Test Plan:
- Kernel k[r][c]=3r+c+1, W=5, mems return addr+{0,10,20}:
  - Kernel pushes, dato0/1/2 in order: (1,4,7), (2,5,8), (3,6,9).
  - 6 image pushes, the last all-zero.
  - o_res_valid high exactly 3 cycles.
  - o_done 1 cycle after the flush push.
- i_start with W=2 -> o_err pulse, o_valid never rises, o_busy stays 0.
- Same pass with i_stall=1 for 4 cycles during the 3rd image push -> identical column sequence, o_addr held at 2 throughout the stall, total cycles +4.
- rst asserted during STREAM column 2 -> next cycle all outputs 0; a new i_start runs a complete clean pass.
- i_start pulsed again while busy -> ignored; exactly one o_done.
- With CONV_FEEDER_ZERO_PAD_EN, W=5 -> 8 image pushes (zero, cols 0-4, zero, zero flush), o_res_valid high 5 cycles.
